// File: rtl/lvds_link_pkg.sv
// Shared constants, state encodings and helpers for the multi-lane LVDS link aligner.
package lvds_link_pkg;

    localparam int unsigned SERIALIZATION = 10;
    localparam int unsigned CHANNELS      = 4;
    localparam int unsigned BUS_W         = SERIALIZATION * CHANNELS;

    localparam logic [SERIALIZATION-1:0] SYNC_PATTERN   = 10'h3F0;
    localparam logic [SERIALIZATION-1:0] MARKER_PATTERN = 10'h0FC;

    localparam int unsigned STABLE_CYCLES = 16;
    localparam int unsigned SLIP_WAIT     = 4;
    localparam int unsigned MAX_SLIPS     = 20;
    localparam int unsigned MAX_SKEW      = 3;
    localparam int unsigned DLY_W         = $clog2(MAX_SKEW + 1);

    localparam int unsigned STABLE_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SLIP_W   = $clog2(MAX_SLIPS + 1);
    localparam int unsigned WAIT_W   = $clog2(SLIP_WAIT + 1);

    localparam logic [2:0] G_IDLE   = 3'd0;
    localparam logic [2:0] G_ALIGN  = 3'd1;
    localparam logic [2:0] G_DESKEW = 3'd2;
    localparam logic [2:0] G_LOCKED = 3'd3;
    localparam logic [2:0] G_FAIL   = 3'd4;

    localparam logic [1:0] L_CHECK = 2'd0;
    localparam logic [1:0] L_SLIP  = 2'd1;
    localparam logic [1:0] L_WAIT  = 2'd2;

    function automatic logic [SERIALIZATION-1:0] lane_slice(input logic [BUS_W-1:0] bus,
                                                            input int unsigned lane);
        return bus[lane*SERIALIZATION +: SERIALIZATION];
    endfunction

    // Both idle and marker words are valid framing during word alignment.
    function automatic logic is_training_word(input logic [SERIALIZATION-1:0] word);
        return (word == SYNC_PATTERN) || (word == MARKER_PATTERN);
    endfunction

endpackage

// File: rtl/lvds_lane_aligner.sv
// One lane: bitslip search with settle wait, stable-match lock, marker detect and delay line.
module lvds_lane_aligner
    import lvds_link_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     run,
    input  logic [SERIALIZATION-1:0] word,
    input  logic [DLY_W-1:0]         delay,
    output logic                     slip,
    output logic                     locked,
    output logic                     fail_c,
    output logic                     marker_c,
    output logic [SERIALIZATION-1:0] data
);

    logic [1:0]               state, state_n;
    logic [STABLE_W-1:0]      stable_cnt, stable_n;
    logic [SLIP_W-1:0]        slip_cnt, slip_n;
    logic [WAIT_W-1:0]        wait_cnt, wait_n;
    logic                     locked_n;
    logic                     slip_n_pulse;
    logic [SERIALIZATION-1:0] pipe [MAX_SKEW];
    logic [SERIALIZATION-1:0] tap;

    assign fail_c   = (slip_cnt == SLIP_W'(MAX_SLIPS));
    assign marker_c = (word == MARKER_PATTERN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= L_CHECK;
            stable_cnt <= '0;
            slip_cnt   <= '0;
            wait_cnt   <= '0;
            locked     <= 1'b0;
            slip       <= 1'b0;
        end else begin
            state      <= state_n;
            stable_cnt <= stable_n;
            slip_cnt   <= slip_n;
            wait_cnt   <= wait_n;
            locked     <= locked_n;
            slip       <= slip_n_pulse;
        end
    end

    // Lane state is frozen whenever the link is not in the alignment phase.
    always_comb begin
        state_n      = state;
        stable_n     = stable_cnt;
        slip_n       = slip_cnt;
        wait_n       = wait_cnt;
        locked_n     = locked;
        slip_n_pulse = 1'b0;
        if (clear) begin
            state_n  = L_CHECK;
            stable_n = '0;
            slip_n   = '0;
            wait_n   = '0;
            locked_n = 1'b0;
        end else if (run) begin
            case (state)
                L_CHECK: begin
                    if (is_training_word(word)) begin
                        if (!locked) begin
                            stable_n = stable_cnt + STABLE_W'(1);
                            if (stable_cnt == STABLE_W'(STABLE_CYCLES - 1)) begin
                                locked_n = 1'b1;
                            end
                        end
                    end else begin
                        stable_n     = '0;
                        locked_n     = 1'b0;
                        slip_n       = slip_cnt + SLIP_W'(1);
                        slip_n_pulse = 1'b1;
                        state_n      = L_SLIP;
                    end
                end
                L_SLIP: begin
                    wait_n  = '0;
                    state_n = L_WAIT;
                end
                L_WAIT: begin
                    if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                        state_n = L_CHECK;
                    end else begin
                        wait_n = wait_cnt + WAIT_W'(1);
                    end
                end
                default: state_n = L_CHECK;
            endcase
        end
    end

    // Tap 0 is the live word; tap k is the word k cycles old.
    always_comb begin
        tap = word;
        for (int unsigned k = 1; k <= MAX_SKEW; k++) begin
            if (delay == DLY_W'(k)) begin
                tap = pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < MAX_SKEW; k++) begin
                pipe[k] <= '0;
            end
            data <= '0;
        end else begin
            pipe[0] <= word;
            for (int unsigned k = 1; k < MAX_SKEW; k++) begin
                pipe[k] <= pipe[k-1];
            end
            data <= tap;
        end
    end

endmodule

// File: rtl/lvds_link_aligner.sv
// Link trainer: per-lane word alignment, then marker-based inter-lane deskew, then ready.
module lvds_link_aligner
    import lvds_link_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_enable,
    input  logic [BUS_W-1:0]            i_data,
    output logic [CHANNELS-1:0]         o_slip_pulse,
    output logic [CHANNELS-1:0]         o_lane_locked,
    output logic [BUS_W-1:0]            o_data,
    output logic [DLY_W*CHANNELS-1:0]   o_delay,
    output logic                        o_ready,
    output logic                        o_error
);

    logic [2:0]                state, state_n;
    logic                      lane_clear, lane_run;
    logic [CHANNELS-1:0]       fail_c, marker_c;
    logic [CHANNELS-1:0]       rec, new_rec, hit;
    logic                      first_seen;
    logic [DLY_W-1:0]          elapsed;
    logic [DLY_W-1:0]          off [CHANNELS];
    logic [DLY_W-1:0]          off_now;
    logic                      all_rec, skew_fail;
    logic [DLY_W*CHANNELS-1:0] delay_new;

    assign lane_clear = (state == G_IDLE) || !i_enable;
    assign lane_run   = (state == G_ALIGN) && i_enable;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        lvds_lane_aligner u_lane (
            .clk      (i_clk),
            .rst_n    (i_rst),
            .clear    (lane_clear),
            .run      (lane_run),
            .word     (lane_slice(i_data, c)),
            .delay    (o_delay[c*DLY_W +: DLY_W]),
            .slip     (o_slip_pulse[c]),
            .locked   (o_lane_locked[c]),
            .fail_c   (fail_c[c]),
            .marker_c (marker_c[c]),
            .data     (o_data[c*SERIALIZATION +: SERIALIZATION])
        );
    end

    // Offsets are measured from the first marker seen; the latest lane gets zero delay.
    always_comb begin
        hit       = marker_c & ~rec;
        new_rec   = rec | hit;
        off_now   = first_seen ? elapsed : '0;
        all_rec   = (state == G_DESKEW) && (&new_rec);
        skew_fail = (state == G_DESKEW) && first_seen &&
                    (elapsed == DLY_W'(MAX_SKEW)) && !(&new_rec);
        delay_new = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (rec[c]) begin
                delay_new[c*DLY_W +: DLY_W] = off_now - off[c];
            end
        end
    end

    always_comb begin
        state_n = state;
        if (!i_enable) begin
            state_n = G_IDLE;
        end else begin
            case (state)
                G_IDLE:   state_n = G_ALIGN;
                G_ALIGN: begin
                    if (|fail_c) begin
                        state_n = G_FAIL;
                    end else if (&o_lane_locked) begin
                        state_n = G_DESKEW;
                    end
                end
                G_DESKEW: begin
                    if (skew_fail) begin
                        state_n = G_FAIL;
                    end else if (all_rec) begin
                        state_n = G_LOCKED;
                    end
                end
                G_LOCKED: state_n = G_LOCKED;
                G_FAIL:   state_n = G_FAIL;
                default:  state_n = G_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= G_IDLE;
            rec        <= '0;
            first_seen <= 1'b0;
            elapsed    <= '0;
            o_delay    <= '0;
            o_ready    <= 1'b0;
            o_error    <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                off[c] <= '0;
            end
        end else begin
            state   <= state_n;
            o_ready <= (state_n == G_LOCKED);
            o_error <= (state_n == G_FAIL);
            if (lane_clear) begin
                rec        <= '0;
                first_seen <= 1'b0;
                elapsed    <= '0;
                o_delay    <= '0;
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    off[c] <= '0;
                end
            end else if (state == G_DESKEW) begin
                rec <= new_rec;
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (hit[c]) begin
                        off[c] <= off_now;
                    end
                end
                if (first_seen) begin
                    if (elapsed != DLY_W'(MAX_SKEW)) begin
                        elapsed <= elapsed + DLY_W'(1);
                    end
                end else if (|hit) begin
                    first_seen <= 1'b1;
                    elapsed    <= DLY_W'(1);
                end
                if (all_rec) begin
                    o_delay <= delay_new;
                end
            end
        end
    end

endmodule

// File: tb/tb_lvds_link_aligner.sv
// Directed bench for lvds_link_aligner with a bitslip-reacting receiver model.
module tb_lvds_link_aligner;
    import lvds_link_pkg::*;

    typedef struct packed {
        logic             grp;
        logic             chk;
        logic [BUS_W-1:0] din;
        logic [BUS_W-1:0] dout;
    } vec_t;

    logic                      i_clk;
    logic                      i_rst;
    logic                      i_enable;
    logic [BUS_W-1:0]          i_data;
    logic [CHANNELS-1:0]       o_slip_pulse;
    logic [CHANNELS-1:0]       o_lane_locked;
    logic [BUS_W-1:0]          o_data;
    logic [DLY_W*CHANNELS-1:0] o_delay;
    logic                      o_ready;
    logic                      o_error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [SERIALIZATION-1:0] base [CHANNELS];
    int rot   [CHANNELS];
    int slips [CHANNELS];
    int p2    [4];
    vec_t vecs [9];

    lvds_link_aligner dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_data        (i_data),
        .o_slip_pulse  (o_slip_pulse),
        .o_lane_locked (o_lane_locked),
        .o_data        (o_data),
        .o_delay       (o_delay),
        .o_ready       (o_ready),
        .o_error       (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [SERIALIZATION-1:0] rotl(input logic [SERIALIZATION-1:0] w, input int r);
        logic [SERIALIZATION-1:0] v;
        v = w;
        for (int i = 0; i < r; i++) v = {v[SERIALIZATION-2:0], v[SERIALIZATION-1]};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: react to slip pulses, drive the next words, sample after the edge.
    task automatic tick();
        logic [BUS_W-1:0] d;
        @(negedge i_clk);
        for (int c = 0; c < CHANNELS; c++) begin
            if (o_slip_pulse[c]) begin
                if (c == 2 && slips[2] < 4) p2[slips[2]] = cyc;
                slips[c]++;
                rot[c] = (rot[c] == 0) ? SERIALIZATION - 1 : rot[c] - 1;
            end
        end
        d = '0;
        for (int c = 0; c < CHANNELS; c++) d[c*SERIALIZATION +: SERIALIZATION] = rotl(base[c], rot[c]);
        i_data = d;
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        i_rst    = 1'b0;
        i_enable = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            base[c] = SYNC_PATTERN;
            rot[c]  = 0;
        end
        tick();
        tick();
        i_rst = 1'b1;
        for (int c = 0; c < CHANNELS; c++) slips[c] = 0;
        for (int i = 0; i < 4; i++) p2[i] = 0;
    endtask

    task automatic wait_locked(output int n);
        n = 0;
        while (o_lane_locked !== 4'hF && n < 300) begin
            tick();
            n++;
        end
    endtask

    // One settling tick, then each lane sends a single marker at its offset.
    task automatic send_markers(input int o0, input int o1, input int o2, input int o3);
        int offs [4];
        int mx;
        offs[0] = o0; offs[1] = o1; offs[2] = o2; offs[3] = o3;
        mx = 0;
        for (int c = 0; c < 4; c++) if (offs[c] > mx) mx = offs[c];
        tick();
        for (int k = 0; k <= mx; k++) begin
            for (int c = 0; c < CHANNELS; c++) base[c] = (offs[c] == k) ? MARKER_PATTERN : SYNC_PATTERN;
            tick();
        end
        for (int c = 0; c < CHANNELS; c++) base[c] = SYNC_PATTERN;
    endtask

    task automatic apply_group(input logic g);
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].grp == g) begin
                for (int c = 0; c < CHANNELS; c++) base[c] = vecs[i].din[c*SERIALIZATION +: SERIALIZATION];
                tick();
                if (vecs[i].chk) check($sformatf("vec%0d_data", i), 64'(o_data), 64'(vecs[i].dout));
            end
        end
        for (int c = 0; c < CHANNELS; c++) base[c] = SYNC_PATTERN;
    endtask

    initial begin
        int n;
        // Aligned link, zero delay: output equals input one cycle later.
        vecs[0] = '{1'b0, 1'b1, {10'h3CC, 10'h0F0, 10'h2AA, 10'h155}, {10'h3CC, 10'h0F0, 10'h2AA, 10'h155}};
        vecs[1] = '{1'b0, 1'b1, {10'h001, 10'h002, 10'h004, 10'h008}, {10'h001, 10'h002, 10'h004, 10'h008}};
        vecs[2] = '{1'b0, 1'b1, {10'h3FF, 10'h000, 10'h3FF, 10'h000}, {10'h3FF, 10'h000, 10'h3FF, 10'h000}};
        // Delays lane0..3 = 2,0,2,1.
        vecs[3] = '{1'b1, 1'b0, {10'h080, 10'h300, 10'h200, 10'h100}, '0};
        vecs[4] = '{1'b1, 1'b0, {10'h081, 10'h301, 10'h201, 10'h101}, '0};
        vecs[5] = '{1'b1, 1'b1, {10'h082, 10'h302, 10'h202, 10'h102}, {10'h081, 10'h300, 10'h202, 10'h100}};
        vecs[6] = '{1'b1, 1'b1, {10'h083, 10'h303, 10'h203, 10'h103}, {10'h082, 10'h301, 10'h203, 10'h101}};
        vecs[7] = '{1'b1, 1'b1, {10'h084, 10'h304, 10'h204, 10'h104}, {10'h083, 10'h302, 10'h204, 10'h102}};
        vecs[8] = '{1'b1, 1'b1, {10'h085, 10'h305, 10'h205, 10'h105}, {10'h084, 10'h303, 10'h205, 10'h103}};

        i_data = '0;
        do_reset();
        check("rst_slip",   64'(o_slip_pulse),  64'(0));
        check("rst_locked", 64'(o_lane_locked), 64'(0));
        check("rst_data",   64'(o_data),        64'(0));
        check("rst_flags",  64'({o_delay, o_ready, o_error}), 64'(0));

        // All lanes aligned, simultaneous markers.
        i_enable = 1'b1;
        wait_locked(n);
        check("t1_lock_latency", 64'(n), 64'(17));
        check("t1_slips", 64'(slips[0] + slips[1] + slips[2] + slips[3]), 64'(0));
        send_markers(0, 0, 0, 0);
        check("t1_ready", 64'(o_ready), 64'(1));
        check("t1_delay", 64'(o_delay), 64'(0));
        apply_group(1'b0);
        check("t1_ready_hold", 64'({o_ready, o_error}), 64'(2));

        // Lane 2 rotated by three bits.
        do_reset();
        rot[2] = 3;
        i_enable = 1'b1;
        wait_locked(n);
        check("t2_locked", 64'(o_lane_locked), 64'(4'hF));
        check("t2_slips2", 64'(slips[2]), 64'(3));
        check("t2_slips_other", 64'(slips[0] + slips[1] + slips[3]), 64'(0));
        check("t2_gap01", 64'(p2[1] - p2[0]), 64'(6));
        check("t2_gap12", 64'(p2[2] - p2[1]), 64'(6));
        send_markers(0, 0, 0, 0);
        check("t2_ready", 64'(o_ready), 64'(1));

        // Lane 1 two words late, lane 3 one word late.
        do_reset();
        i_enable = 1'b1;
        wait_locked(n);
        send_markers(0, 2, 0, 1);
        check("t3_ready", 64'(o_ready), 64'(1));
        check("t3_delay", 64'(o_delay), 64'(8'h62));
        apply_group(1'b1);

        // Lane 0 four words late exceeds correctable skew.
        do_reset();
        i_enable = 1'b1;
        wait_locked(n);
        send_markers(4, 0, 0, 0);
        check("t4_error", 64'({o_error, o_ready}), 64'(2));
        for (int i = 0; i < 8; i++) tick();
        check("t4_error_hold", 64'({o_error, o_ready}), 64'(2));
        i_enable = 1'b0;
        tick();
        check("t4_error_clear", 64'({o_error, o_ready}), 64'(0));
        check("t4_lock_clear", 64'(o_lane_locked), 64'(0));

        // Lane 3 stuck at zero exhausts the slip budget.
        do_reset();
        base[3] = '0;
        i_enable = 1'b1;
        n = 0;
        while (o_error !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("t5_error", 64'(o_error), 64'(1));
        check("t5_slips3", 64'(slips[3]), 64'(20));
        check("t5_slips_other", 64'(slips[0] + slips[1] + slips[2]), 64'(0));
        for (int i = 0; i < 10; i++) tick();
        check("t5_no_more_slips", 64'(slips[3]), 64'(20));
        check("t5_error_hold", 64'({o_error, o_ready}), 64'(2));
        i_enable = 1'b0;
        tick();
        check("t5_error_clear", 64'(o_error), 64'(0));
        base[3] = SYNC_PATTERN;
        rot[3] = 0;
        for (int c = 0; c < CHANNELS; c++) slips[c] = 0;
        i_enable = 1'b1;
        wait_locked(n);
        check("t5_relock_latency", 64'(n), 64'(17));
        send_markers(0, 0, 0, 0);
        check("t5_ready", 64'({o_ready, o_error}), 64'(2));

        // Reset asserted during deskew, then retrain.
        do_reset();
        i_enable = 1'b1;
        wait_locked(n);
        tick();
        i_rst = 1'b0;
        tick();
        check("t6_rst_locked", 64'(o_lane_locked), 64'(0));
        check("t6_rst_data", 64'(o_data), 64'(0));
        check("t6_rst_flags", 64'({o_slip_pulse, o_delay, o_ready, o_error}), 64'(0));
        i_rst = 1'b1;
        wait_locked(n);
        check("t6_relock_latency", 64'(n), 64'(17));
        send_markers(0, 1, 0, 0);
        check("t6_ready", 64'(o_ready), 64'(1));
        check("t6_delay", 64'(o_delay), 64'(8'h51));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
